// File: rtl/sdm_adc_pkg.sv
// Shared types and defaults for the SDM/ADC acquisition sequencer.
// Holds the state encoding, the default strobe periods and the period-resolve helper.
package sdm_adc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } acq_state_e;

  localparam int unsigned AdcCycDefault = 20;
  localparam int unsigned SdmCycDefault = 4;

  // A period below 2 cannot produce distinct one-cycle pulses, so it falls back to the default.
  function automatic int unsigned resolve_period(input int unsigned val, input int unsigned dflt);
    return (val < 2) ? dflt : val;
  endfunction

endpackage

// File: rtl/sdm_adc_acq_sequencer_strobe_gen.sv
// Programmable period counter producing a registered one-cycle strobe.
// issued_o/dropped_o report, at the raising edge, whether the strobe goes out or is suppressed.
module sdm_adc_acq_sequencer_strobe_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             count_i,
  input  logic             gate_i,
  input  logic             suppress_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             strobe_o,
  output logic             issued_o,
  output logic             dropped_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;
  logic             hit;

  assign hit = count_i && (cnt_q == (period_i - DIV_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = hit ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // The counter keeps running when suppressed so the time base is not shifted.
  always_comb begin
    issued_o  = hit && gate_i && !suppress_i;
    dropped_o = hit && gate_i && suppress_i;
    strobe_d  = issued_o;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/sdm_adc_acq_sequencer.sv
// Acquisition controller generating ADC/SDM sample strobes for the data aggregator.
// Runs finite or continuous acquisitions, honours FIFO backpressure and counts dropped frames.
module sdm_adc_acq_sequencer
  import sdm_adc_pkg::*;
#(
  parameter int unsigned ADC_CYC = AdcCycDefault,
  parameter int unsigned SDM_CYC = SdmCycDefault,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             trig_sel,
  input  logic             trig_ext,
  input  logic [CNT_W-1:0] n_frames,
  input  logic [DIV_W-1:0] adc_div,
  input  logic [DIV_W-1:0] sdm_div,
  input  logic             fifo_full,
  output logic             adc_q_valid,
  output logic             sdm_q_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  acq_state_e       state_q, state_d;
  logic [DIV_W-1:0] adc_per_q, adc_per_d;
  logic [DIV_W-1:0] sdm_per_q, sdm_per_d;
  logic [CNT_W-1:0] n_frames_q, n_frames_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             trig_prev_q;
  logic             launch, last_frame, running, gate;
  logic             adc_issued, adc_dropped;
  logic             unused_sdm_issued, unused_sdm_dropped;

  // The strobe that brought frame_cnt up to the target is visible now, so stop after it.
  assign last_frame = adc_q_valid && (n_frames_q != '0) && (frame_cnt_q == n_frames_q);
  assign running    = (state_q == StRun);
  assign gate       = (state_d == StRun);

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          launch  = 1'b1;
          state_d = stop ? StDone : StArm;
        end
      end
      StArm: begin
        if (stop) begin
          state_d = StDone;
        end else if (!trig_sel || (trig_ext && !trig_prev_q)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop || last_frame) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    adc_per_d   = adc_per_q;
    sdm_per_d   = sdm_per_q;
    n_frames_d  = n_frames_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (launch) begin
      adc_per_d   = DIV_W'(resolve_period(32'(adc_div), ADC_CYC));
      sdm_per_d   = DIV_W'(resolve_period(32'(sdm_div), SDM_CYC));
      n_frames_d  = n_frames;
      frame_cnt_d = '0;
      drop_cnt_d  = '0;
    end else begin
      if (adc_issued) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
      if (adc_dropped && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
    busy_d = (state_d == StArm) || (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      adc_per_q   <= DIV_W'(ADC_CYC);
      sdm_per_q   <= DIV_W'(SDM_CYC);
      n_frames_q  <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      adc_per_q   <= adc_per_d;
      sdm_per_q   <= sdm_per_d;
      n_frames_q  <= n_frames_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trig_prev_q <= trig_ext;
    end
  end

  sdm_adc_acq_sequencer_strobe_gen #(
    .DIV_W(DIV_W)
  ) u_adc_strobe (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!running),
    .count_i   (running),
    .gate_i    (gate),
    .suppress_i(fifo_full),
    .period_i  (adc_per_q),
    .strobe_o  (adc_q_valid),
    .issued_o  (adc_issued),
    .dropped_o (adc_dropped)
  );

  sdm_adc_acq_sequencer_strobe_gen #(
    .DIV_W(DIV_W)
  ) u_sdm_strobe (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!running),
    .count_i   (running),
    .gate_i    (gate),
    .suppress_i(fifo_full),
    .period_i  (sdm_per_q),
    .strobe_o  (sdm_q_valid),
    .issued_o  (unused_sdm_issued),
    .dropped_o (unused_sdm_dropped)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_sdm_adc_acq_sequencer.sv
// Bench for sdm_adc_acq_sequencer: directed and randomized acquisitions against a
// timeline model built from strobe arithmetic (R + k*P, backpressure window, stop/finish).
module tb_sdm_adc_acq_sequencer;

  localparam int NCYC = 170;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        trig_sel = 1'b0;
  logic        trig_ext = 1'b0;
  logic [31:0] n_frames = '0;
  logic [7:0]  adc_div = '0;
  logic [7:0]  sdm_div = '0;
  logic        fifo_full = 1'b0;
  logic        adc_q_valid, sdm_q_valid, busy, done;
  logic [31:0] frame_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;
  int sc = 0;

  bit          exp_adc[NCYC];
  bit          exp_sdm[NCYC];
  bit          exp_busy[NCYC];
  bit          exp_done[NCYC];
  int unsigned exp_frame[NCYC];
  int unsigned exp_drop[NCYC];

  sdm_adc_acq_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .trig_sel   (trig_sel),
    .trig_ext   (trig_ext),
    .n_frames   (n_frames),
    .adc_div    (adc_div),
    .sdm_div    (sdm_div),
    .fifo_full  (fifo_full),
    .adc_q_valid(adc_q_valid),
    .sdm_q_valid(sdm_q_valid),
    .busy       (busy),
    .done       (done),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Expected timeline: start at cycle 0, run begins at R, strobes at R+k*P while the run lasts.
  task automatic build_model(input int adiv, input int sdiv, input int n, input bit tsel,
                             input int tc, input int stop_c, input int full_lo,
                             input int full_hi);
    int pa, ps, r, end_c, frames, drops;
    bit full;
    pa = (adiv < 2) ? 20 : adiv;
    ps = (sdiv < 2) ? 4 : sdiv;
    r = tsel ? tc + 1 : 2;
    end_c = (stop_c >= 0) ? stop_c + 1 : NCYC + 1000;
    frames = 0;
    drops = 0;
    for (int t = 0; t < NCYC; t++) begin
      exp_adc[t] = 1'b0;
      exp_sdm[t] = 1'b0;
      if (t >= 1 && t < end_c && t > r) begin
        full = (t - 1 >= full_lo) && (t - 1 <= full_hi);
        if (((t - r) % ps == 0) && !full) exp_sdm[t] = 1'b1;
        if ((t - r) % pa == 0) begin
          if (full) begin
            drops++;
          end else begin
            frames++;
            exp_adc[t] = 1'b1;
            if (n != 0 && frames == n) end_c = t + 1;
          end
        end
      end
      exp_frame[t] = frames;
      exp_drop[t]  = drops;
      exp_busy[t]  = (t >= 1) && (t < end_c);
      exp_done[t]  = (t >= end_c);
    end
  endtask

  task automatic run_scenario(input int adiv, input int sdiv, input int n, input bit tsel,
                              input int tc, input int stop_c, input int full_lo,
                              input int full_hi);
    build_model(adiv, sdiv, n, tsel, tc, stop_c, full_lo, full_hi);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        checks += 6;
        if (adc_q_valid !== exp_adc[c]) begin
          errors++;
          $display("FAIL adc_q_valid sc%0d c%0d: got %b expected %b", sc, c, adc_q_valid,
                   exp_adc[c]);
        end
        if (sdm_q_valid !== exp_sdm[c]) begin
          errors++;
          $display("FAIL sdm_q_valid sc%0d c%0d: got %b expected %b", sc, c, sdm_q_valid,
                   exp_sdm[c]);
        end
        if (busy !== exp_busy[c]) begin
          errors++;
          $display("FAIL busy sc%0d c%0d: got %b expected %b", sc, c, busy, exp_busy[c]);
        end
        if (done !== exp_done[c]) begin
          errors++;
          $display("FAIL done sc%0d c%0d: got %b expected %b", sc, c, done, exp_done[c]);
        end
        if (frame_cnt !== exp_frame[c]) begin
          errors++;
          $display("FAIL frame_cnt sc%0d c%0d: got %0d expected %0d", sc, c, frame_cnt,
                   exp_frame[c]);
        end
        if (drop_cnt !== exp_drop[c]) begin
          errors++;
          $display("FAIL drop_cnt sc%0d c%0d: got %0d expected %0d", sc, c, drop_cnt,
                   exp_drop[c]);
        end
      end
      start     = (c == 0);
      stop      = (c == stop_c);
      trig_sel  = tsel;
      trig_ext  = tsel && ((c < 2) || (c >= tc));
      fifo_full = (c >= full_lo) && (c <= full_hi);
      n_frames  = n;
      adc_div   = 8'(adiv);
      sdm_div   = 8'(sdiv);
    end
    start     = 1'b0;
    stop      = 1'b0;
    trig_ext  = 1'b0;
    fifo_full = 1'b0;
    sc++;
  endtask

  task automatic check_all_zero(input string tag);
    checks += 6;
    if (adc_q_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s adc_q_valid: got %b expected 0", tag, adc_q_valid);
    end
    if (sdm_q_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s sdm_q_valid: got %b expected 0", tag, sdm_q_valid);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %b expected 0", tag, busy);
    end
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got %b expected 0", tag, done);
    end
    if (frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL %s frame_cnt: got %0d expected 0", tag, frame_cnt);
    end
    if (drop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL %s drop_cnt: got %0d expected 0", tag, drop_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_defaults();
    run_scenario(0, 0, 3, 1'b0, 0, -1, 1000, 1000);
  endtask

  task automatic test_backpressure();
    run_scenario(0, 1, 3, 1'b0, 0, -1, 40, 43);
  endtask

  task automatic test_trigger();
    run_scenario(0, 0, 1, 1'b1, 30, -1, 1000, 1000);
  endtask

  task automatic test_continuous_stop();
    run_scenario(5, 1, 0, 1'b0, 0, 40, 1000, 1000);
  endtask

  task automatic test_start_stop_same_cycle();
    run_scenario(0, 0, 3, 1'b0, 0, 0, 1000, 1000);
    run_scenario(3, 2, 2, 1'b0, 0, -1, 1000, 1000);
  endtask

  task automatic test_random();
    int adiv, sdiv, n, tc, stop_c, lo;
    bit tsel;
    for (int i = 0; i < 8; i++) begin
      adiv = $urandom_range(0, 12);
      sdiv = $urandom_range(0, 9);
      n    = $urandom_range(0, 5);
      tsel = 1'($urandom_range(0, 1));
      tc   = $urandom_range(3, 20);
      if (n == 0 || $urandom_range(0, 1) == 1) stop_c = $urandom_range(10, 120);
      else stop_c = -1;
      lo = $urandom_range(0, 100);
      run_scenario(adiv, sdiv, n, tsel, tc, stop_c, lo, lo + $urandom_range(0, 10));
    end
  endtask

  task automatic test_reset_mid_run();
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (c == 22) begin
        checks++;
        if (adc_q_valid !== 1'b1) begin
          errors++;
          $display("FAIL midrst adc_q_valid c22: got %b expected 1", adc_q_valid);
        end
      end
      if (c == 25) begin
        checks++;
        if (busy !== 1'b1 || frame_cnt !== 32'd1) begin
          errors++;
          $display("FAIL midrst run c25: got busy=%b frame=%0d expected busy=1 frame=1",
                   busy, frame_cnt);
        end
      end
      start    = (c == 0);
      n_frames = '0;
      adc_div  = '0;
      sdm_div  = '0;
      trig_sel = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_all_zero("midrst_async");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks += 4;
      if (adc_q_valid !== 1'b0 || sdm_q_valid !== 1'b0) begin
        errors += 2;
        $display("FAIL midrst strobes c%0d: got adc=%b sdm=%b expected 0", c, adc_q_valid,
                 sdm_q_valid);
      end
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors += 2;
        $display("FAIL midrst idle c%0d: got busy=%b done=%b expected 0", c, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_backpressure();
    test_trigger();
    test_continuous_stop();
    test_start_stop_same_cycle();
    test_random();
    test_reset_mid_run();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdm_adc_acq_sequencer.md
Name: sdm_adc_acq_sequencer

Overview:
- Acquisition controller that generates the ADC_Q_VALID / SDM_Q_VALID sample strobes feeding sdm_adc_data_aggregator.
- Runs programmable-length or continuous acquisitions from start, stop and optional external-trigger commands.
- Suppresses strobes while the aggregator FIFO is full and counts dropped ADC frames.
- Sits between the slow-control register file and the aggregator, in the clk domain.

Parameters:
- ADC_CYC, 20, default ADC strobe period in clk cycles.
- SDM_CYC, 4, default SDM strobe period in clk cycles.
- DIV_W, 8, width of the runtime period fields.
- CNT_W, 32, width of the frame and drop counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle start command
- stop  in  1  one-cycle stop command
- trig_sel  in  1  1 = wait for trig_ext in ARM; 0 = free start
- trig_ext  in  1  external trigger, synchronous to clk
- n_frames  in  CNT_W  ADC frames per run; 0 = continuous
- adc_div  in  DIV_W  ADC period; values <2 select ADC_CYC
- sdm_div  in  DIV_W  SDM period; values <2 select SDM_CYC
- fifo_full  in  1  aggregator FIFO full
- adc_q_valid  out  1  ADC sample strobe
- sdm_q_valid  out  1  SDM sample strobe
- busy  out  1  high in ARM or RUN
- done  out  1  high in DONE
- frame_cnt  out  CNT_W  ADC frames issued this run
- drop_cnt  out  CNT_W  ADC frames suppressed this run, saturating

Behaviour:
- States: IDLE, ARM, RUN, DONE. All outputs are registered.
- Reset (async, any time, including mid-run):
  - State goes to IDLE.
  - All outputs go to 0. Period counters clear.
- IDLE or DONE with start=1:
  - Go to ARM on the next cycle.
  - Latch adc_div, sdm_div and n_frames, resolving values <2 to the parameter defaults.
  - Clear frame_cnt and drop_cnt.
- start in ARM or RUN is ignored.
- stop in ARM or RUN goes to DONE on the next cycle.
- start and stop in the same cycle: stop wins.
- ARM:
  - trig_sel=0: go to RUN on the next cycle.
  - trig_sel=1: go to RUN on the cycle after a trig_ext rising edge (edge detection uses a registered previous value; a level that is already high on entry to ARM does not count).
- RUN, with R = first RUN cycle:
  - Both period counters are 0 at R.
  - adc_q_valid is a one-cycle pulse at cycles R+P_adc, R+2·P_adc, and so on.
  - sdm_q_valid is a one-cycle pulse at R+P_sdm, R+2·P_sdm, and so on, independent of the ADC phase.
  - Coincident ADC and SDM strobes are both issued.
- Backpressure:
  - fifo_full is sampled at the edge that would raise a strobe; if it is 1, that strobe stays 0.
  - Period counters keep running, so the time base is preserved.
  - A suppressed ADC strobe increments drop_cnt (saturating at all-ones) and does not increment frame_cnt.
  - Suppressed SDM strobes are not counted.
- Every issued ADC strobe increments frame_cnt in the same cycle the strobe is high. frame_cnt wraps only in continuous mode.
- When n_frames≠0 and the issued strobe makes frame_cnt equal n_frames, the state is DONE on the next cycle, and no further strobes are issued.
- DONE:
  - done=1 and busy=0.
  - Counters hold their values until the next start.

Decomposition:
- Shared package sdm_adc_pkg holds:
  - the state enum (IDLE=0, ARM=1, RUN=2, DONE=3);
  - the ADC_CYC/SDM_CYC defaults;
  - the period-resolve function (value <2 → default).
- One natural sub-module: strobe_gen, a programmable period counter with clear, enable and suppress inputs, producing a strobe output and an issued/suppressed flag. Instantiated twice, once for ADC and once for SDM.

Test Plan:
- Defaults (P_adc=20, P_sdm=4), n_frames=3, trig_sel=0, start at cycle 0 → RUN from cycle 2; adc_q_valid at 22, 42, 62; sdm_q_valid at 6, 10, …, 62 (15 pulses); done=1 from 63; frame_cnt=3; drop_cnt=0.
- Same setup, fifo_full high during cycles 40–43 → no ADC strobe at 42 and no SDM strobes at 42; drop_cnt=1; ADC strobes at 22, 62, 82; done from 83; frame_cnt=3.
- trig_sel=1, trig_ext held high before start, then a rising edge at cycle 30 → stays in ARM until the edge; RUN from 31; first adc_q_valid at 51.
- adc_div=5, sdm_div=1, n_frames=0, start then stop at cycle 40 → ADC period 5, SDM period 4 (default); DONE at 41; frame_cnt=7 (ADC strobes at 7, 12, …, 37).
- start and stop in the same cycle while in IDLE → go to DONE directly with no strobes; a later start alone → ARM with counters cleared.
- reset asserted at cycle 30 during RUN → outputs 0 immediately; state IDLE; after reset release, strobes stay 0 until a new start.
